toggle_event_tx: RTL and testbench

- Transmit end of the single-wire toggle signalling link. Each accepted event becomes exactly one transition on line_out.
- The far end recovers events with a two-flop XOR edge detector, which produces one pulse per transition.
- The block queues event requests as a pending count and spaces transitions at least MIN_GAP cycles apart, so no edge is merged or lost at the receiver.
- It sits between event sources (interrupt or strobe logic) and the link wire.

---
 rtl/toggle_event_tx.sv | 87 ++++++++
 tb/tb_toggle_event_tx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_tx.sv
// Toggle-signalling link transmitter: queues event requests and emits one
// line_out transition per event, spaced at least MIN_GAP cycles apart.
module toggle_event_tx #(
  parameter int MIN_GAP = 3,
  parameter int CNT_W   = 4,
  parameter int TXC_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic             clr,
  output logic             line_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic [TXC_W-1:0] tx_count,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       gap_q, gap_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             line_q, line_d;
  logic [TXC_W-1:0] txc_q, txc_d;
  logic             ovf_q, ovf_d;
  logic             full, accept, send;

  assign full     = (pend_q == {CNT_W{1'b1}});
  assign ev_ready = !full && !clr;
  assign accept   = ev_valid && ev_ready;
  // Send decision uses registered pending only; clr suppresses it.
  assign send     = (state_q == IDLE) && (pend_q != '0) && !clr;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    line_d  = line_q;
    txc_d   = txc_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    if (state_q == IDLE) begin
      if (send) begin
        state_d = GAP;
        gap_d   = 8'(MIN_GAP - 1);
        line_d  = !line_q;
        txc_d   = txc_q + TXC_W'(1);
      end
    end else begin
      gap_d = gap_q - 8'd1;
      if (gap_q <= 8'd1) state_d = IDLE;
    end

    if (clr)                 pend_d = '0;
    else if (accept && !send) pend_d = pend_q + CNT_W'(1);
    else if (send && !accept) pend_d = pend_q - CNT_W'(1);

    if (ev_valid && !ev_ready && !clr) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gap_q   <= '0;
      line_q  <= 1'b0;
      txc_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      line_q  <= line_d;
      txc_q   <= txc_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign line_out = line_q;
  assign busy     = (state_q == GAP) || (pend_q != '0);
  assign pending  = pend_q;
  assign tx_count = txc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_toggle_event_tx.sv
// Directed bench: default-size instance for timing/clr/reset, a narrow
// instance (CNT_W=2, TXC_W=3) for saturation, overflow and count wrap.
module tb_toggle_event_tx;
  logic clk, resetn;
  logic a_valid, a_clr, a_ready, a_line, a_busy, a_ovf;
  logic [3:0]  a_pend;
  logic [15:0] a_txc;
  logic b_valid, b_clr, b_ready, b_line, b_busy, b_ovf;
  logic [1:0] b_pend;
  logic [2:0] b_txc;

  int checks = 0;
  int errors = 0;

  toggle_event_tx #(.MIN_GAP(3), .CNT_W(4), .TXC_W(16)) dut_a (
    .clk(clk), .resetn(resetn), .ev_valid(a_valid), .ev_ready(a_ready),
    .clr(a_clr), .line_out(a_line), .busy(a_busy), .pending(a_pend),
    .tx_count(a_txc), .overflow(a_ovf));

  toggle_event_tx #(.MIN_GAP(3), .CNT_W(2), .TXC_W(3)) dut_b (
    .clk(clk), .resetn(resetn), .ev_valid(b_valid), .ev_ready(b_ready),
    .clr(b_clr), .line_out(b_line), .busy(b_busy), .pending(b_pend),
    .tx_count(b_txc), .overflow(b_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Far-end two-flop XOR edge detector on dut_a's line.
  logic r1, r2;
  int   npulse;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r1 <= 1'b0; r2 <= 1'b0; npulse <= 0;
    end else begin
      r1 <= a_line; r2 <= r1;
      if (r1 ^ r2) npulse <= npulse + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    tick();
  endtask

  int ntog, last, first;
  logic prev;

  initial begin
    resetn = 1'b0;
    a_valid = 0; a_clr = 0; b_valid = 0; b_clr = 0;
    #12;
    chk("rst_line", 32'(a_line), 0);
    chk("rst_pend", 32'(a_pend), 0);
    chk("rst_txc", 32'(a_txc), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    @(negedge clk); resetn = 1'b1;
    tick();
    chk("rst_ready", 32'(a_ready), 1);

    // 1: single event
    a_valid = 1; tick(); a_valid = 0;
    chk("t1_pend1", 32'(a_pend), 1);
    chk("t1_line_hold", 32'(a_line), 0);
    tick();
    chk("t1_line", 32'(a_line), 1);
    chk("t1_pend0", 32'(a_pend), 0);
    chk("t1_txc", 32'(a_txc), 1);
    tick();
    chk("t1_busy_gap", 32'(a_busy), 1);
    tick();
    chk("t1_idle", 32'(a_busy), 0);
    tick();
    chk("t1_busy_low", 32'(a_busy), 0);

    // 2: burst of 5 with backlog, transitions exactly 3 apart
    do_reset();
    ntog = 0; last = 0; first = 0; prev = a_line;
    for (int i = 1; i <= 24; i++) begin
      a_valid = (i <= 5);
      tick();
      if (i == 5) chk("t2_pend_peak", 32'(a_pend), 3);
      if (a_line != prev) begin
        ntog++;
        if (ntog == 1) first = i;
        else chk("t2_spacing", 32'(i - last), 3);
        last = i;
        prev = a_line;
      end
    end
    a_valid = 0;
    chk("t2_first", 32'(first), 2);
    chk("t2_ntog", 32'(ntog), 5);
    chk("t2_line", 32'(a_line), 1);
    chk("t2_txc", 32'(a_txc), 5);
    chk("t2_pulses", 32'(npulse), 5);
    chk("t2_pend", 32'(a_pend), 0);

    // 4: accept and send on the same edge with pending=2
    do_reset();
    a_valid = 1; tick(); tick(); tick();
    a_valid = 0; tick();
    chk("t4_pend_pre", 32'(a_pend), 2);
    chk("t4_line_pre", 32'(a_line), 1);
    a_valid = 1; tick(); a_valid = 0;
    chk("t4_pend", 32'(a_pend), 2);
    chk("t4_line", 32'(a_line), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_drain_txc", 32'(a_txc), 4);

    // 5: clr during a gap, then clr colliding with an idle send
    do_reset();
    a_valid = 1;
    for (int i = 0; i < 5; i++) tick();
    a_valid = 0;
    chk("t5_pend3", 32'(a_pend), 3);
    a_clr = 1; #1;
    chk("t5_ready_clr", 32'(a_ready), 0);
    tick(); a_clr = 0;
    chk("t5_pend_clr", 32'(a_pend), 0);
    chk("t5_busy_gap", 32'(a_busy), 1);
    tick();
    chk("t5_gap_done", 32'(a_busy), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_line", 32'(a_line), 0);
    chk("t5_txc", 32'(a_txc), 2);
    a_valid = 1; tick();
    chk("t5_pend1", 32'(a_pend), 1);
    a_clr = 1; tick(); a_clr = 0; a_valid = 0;
    chk("t5_sup_line", 32'(a_line), 0);
    chk("t5_sup_txc", 32'(a_txc), 2);
    chk("t5_sup_pend", 32'(a_pend), 0);
    chk("t5_sup_busy", 32'(a_busy), 0);
    chk("t5_no_ovf", 32'(a_ovf), 0);

    // 6: asynchronous reset mid-gap with pending=2
    do_reset();
    a_valid = 1; tick(); tick(); tick(); a_valid = 0;
    chk("t6_pend_pre", 32'(a_pend), 2);
    chk("t6_line_pre", 32'(a_line), 1);
    #2 resetn = 1'b0; #1;
    chk("t6_line", 32'(a_line), 0);
    chk("t6_pend", 32'(a_pend), 0);
    chk("t6_txc", 32'(a_txc), 0);
    chk("t6_busy", 32'(a_busy), 0);
    @(negedge clk); resetn = 1'b1;
    tick();
    chk("t6_ready", 32'(a_ready), 1);
    a_valid = 1; tick(); a_valid = 0; tick();
    chk("t6_next", 32'(a_line), 1);

    // 3: narrow queue saturates, overflow sticks, tx_count wraps
    do_reset();
    b_valid = 1;
    ntog = 0; prev = b_line;
    for (int i = 1; i <= 30; i++) begin
      b_valid = (i <= 20);
      tick();
      if (b_line != prev) begin ntog++; prev = b_line; end
      if (i == 4) begin
        chk("t3_full", 32'(b_pend), 3);
        chk("t3_ready", 32'(b_ready), 0);
        chk("t3_ovf_pre", 32'(b_ovf), 0);
      end
      if (i == 5) begin
        chk("t3_ovf", 32'(b_ovf), 1);
        chk("t3_pend5", 32'(b_pend), 2);
      end
    end
    chk("t3_ntog", 32'(ntog), 9);
    chk("t3_txc_wrap", 32'(b_txc), 1);
    chk("t3_pend", 32'(b_pend), 0);
    chk("t3_line", 32'(b_line), 1);
    chk("t3_ovf_sticky", 32'(b_ovf), 1);
    chk("t3_busy", 32'(b_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
